// File: rtl/uart_line_buffer.sv
// Line-editing stage between uart_rx and uart_tx: echo, backspace, CR playback.
// Define UART_LINE_UPCASE_EN to upper-case letters during line playback.
module uart_line_buffer #(
  parameter int DEPTH = 32,
  localparam int LEN_W = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [7:0]       i_rx_data,
  input  logic             i_rx_valid,
  output logic [7:0]       o_tx_data,
  output logic             o_tx_valid,
  input  logic             i_tx_busy,
  output logic [LEN_W-1:0] o_line_len,
  output logic             o_overflow,
  output logic             o_drop,
  output logic [2:0]       o_state,
  output logic [1:0]       o_phase
);
  localparam int IDX_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ECHO      = 3'd1,
    S_ERASE     = 3'd2,
    S_PLAY_HEAD = 3'd3,
    S_PLAY_BODY = 3'd4,
    S_PLAY_TAIL = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    P_EMIT = 2'd0,
    P_GAP  = 2'd1,
    P_WAIT = 2'd2
  } phase_t;

  state_t           state;
  phase_t           phase;
  logic [7:0]       buf_mem [DEPTH];
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] idx;
  logic [7:0]       echo_char;
  logic             pend_valid;
  logic [7:0]       pend_data;
  logic             len_inc;
  logic             len_dec;
  logic [7:0]       tx_char;
  logic             last_char;

  wire consume   = (state == S_IDLE) && pend_valid;
  wire printable = (pend_data >= 8'h20) && (pend_data <= 8'h7E);
  wire is_bs     = (pend_data == 8'h08) || (pend_data == 8'h7F);
  wire is_cr     = (pend_data == 8'h0D);
  wire full      = (len == LEN_W'(DEPTH));
  wire buf_we    = consume && printable && !full;

  assign o_line_len = len;
  assign o_state    = state;
  assign o_phase    = phase;

  always_ff @(posedge i_clk) begin
    if (buf_we) buf_mem[len[IDX_W-1:0]] <= pend_data;
  end

  // Byte to send for the current state and character index.
  always_comb begin
    tx_char = 8'h00;
    case (state)
      S_ECHO:  tx_char = echo_char;
      S_ERASE: tx_char = (idx == LEN_W'(1)) ? 8'h20 : 8'h08;
      S_PLAY_HEAD,
      S_PLAY_TAIL: tx_char = (idx == LEN_W'(0)) ? 8'h0D : 8'h0A;
      S_PLAY_BODY: begin
        tx_char = buf_mem[idx[IDX_W-1:0]];
`ifdef UART_LINE_UPCASE_EN
        if (tx_char >= 8'h61 && tx_char <= 8'h7A) tx_char = tx_char - 8'h20;
`endif
      end
      default: tx_char = 8'h00;
    endcase
  end

  always_comb begin
    last_char = 1'b1;
    case (state)
      S_ERASE:     last_char = (idx == LEN_W'(2));
      S_PLAY_HEAD,
      S_PLAY_TAIL: last_char = (idx == LEN_W'(1));
      S_PLAY_BODY: last_char = (idx == len - LEN_W'(1));
      default:     last_char = 1'b1;
    endcase
  end

  // TX handshake: o_tx_valid is a one-cycle pulse issued only when i_tx_busy
  // is low; the following GAP cycle covers the edge where uart_tx raises busy.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= S_IDLE;
      phase      <= P_EMIT;
      idx        <= '0;
      len        <= '0;
      echo_char  <= 8'h00;
      pend_valid <= 1'b0;
      pend_data  <= 8'h00;
      len_inc    <= 1'b0;
      len_dec    <= 1'b0;
      o_tx_valid <= 1'b0;
      o_tx_data  <= 8'h00;
      o_overflow <= 1'b0;
      o_drop     <= 1'b0;
    end else begin
      o_drop <= i_rx_valid && pend_valid && !consume;
      if (consume) pend_valid <= 1'b0;
      if (i_rx_valid && (!pend_valid || consume)) begin
        pend_valid <= 1'b1;
        pend_data  <= i_rx_data;
      end

      // Length changes land one cycle after classification.
      len_inc <= 1'b0;
      len_dec <= 1'b0;
      if (len_inc)      len <= len + LEN_W'(1);
      else if (len_dec) len <= len - LEN_W'(1);

      o_tx_valid <= 1'b0;
      if (state == S_IDLE) begin
        phase <= P_EMIT;
        idx   <= '0;
        if (pend_valid) begin
          if (printable) begin
            state <= S_ECHO;
            if (!full) begin
              len_inc   <= 1'b1;
              echo_char <= pend_data;
            end else begin
              o_overflow <= 1'b1;
              echo_char  <= 8'h07;
            end
          end else if (is_bs && len != '0) begin
            len_dec <= 1'b1;
            state   <= S_ERASE;
          end else if (is_cr) begin
            state <= S_PLAY_HEAD;
          end
        end
      end else begin
        case (phase)
          P_EMIT: if (!i_tx_busy) begin
            o_tx_valid <= 1'b1;
            o_tx_data  <= tx_char;
            phase      <= P_GAP;
          end
          P_GAP: phase <= P_WAIT;
          P_WAIT: if (!i_tx_busy) begin
            phase <= P_EMIT;
            if (!last_char) begin
              idx <= idx + LEN_W'(1);
            end else begin
              idx <= '0;
              case (state)
                S_PLAY_HEAD: state <= (len == '0) ? S_PLAY_TAIL : S_PLAY_BODY;
                S_PLAY_BODY: state <= S_PLAY_TAIL;
                S_PLAY_TAIL: begin
                  state      <= S_IDLE;
                  len        <= '0;
                  o_overflow <= 1'b0;
                end
                default: state <= S_IDLE;
              endcase
            end
          end
          default: phase <= P_EMIT;
        endcase
      end
    end
  end
endmodule
